free_list: RTL
==============

Name: free_list

Overview:
- Circular FIFO of free physical-register tags. Sits between the commit port of the reorder buffer and the rename stage.
- Rename pops one tag per cycle to use as p_new for a destination register.
- Commit pushes the retiring instruction's p_old back into the list.
- Keeps a speculative read pointer and an architectural (committed) read pointer, so that a flush restores the list in one cycle.

Parameters:
- NUM_PHYS_REGS, 64, total physical registers. Defined in cpu_design_params.
- NUM_ARCH_REGS, 32, architectural registers. Defined in cpu_design_params.
- FL_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS (32), list entries. Must be a power of 2 so pointers wrap naturally.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- alloc_req  in  1  rename requests one physical register this cycle
- alloc_ready  out  1  a free tag is available (spec_count != 0)
- alloc_preg  out  PREG_W  tag at the speculative head; valid when alloc_ready
- commit_valid  in  1  ROB retired an instruction this cycle
- commit_writes_rd  in  1  the retired instruction allocated a destination
- commit_p_old  in  PREG_W  previous mapping to be freed
- flush  in  1  mispredict/exception recovery
- free_count  out  COUNT_W  speculative number of free tags
- overflow_err  out  1  sticky; set on an illegal push

Behaviour:
- Widths:
  - PREG_W = $clog2(NUM_PHYS_REGS).
  - PTR_W = $clog2(FL_DEPTH).
  - COUNT_W = $clog2(FL_DEPTH+1).
  - Pointer arithmetic is modulo FL_DEPTH.
- Reset (async):
  - entry[i] = NUM_ARCH_REGS + i.
  - spec_head = arch_head = tail = 0.
  - spec_count = FL_DEPTH.
  - overflow_err = 0.
  - Outputs after reset: alloc_ready=1, alloc_preg=NUM_ARCH_REGS, free_count=FL_DEPTH.
- Events:
  - pop = alloc_req && alloc_ready && !flush.
  - push = commit_valid && commit_writes_rd.
- Pop:
  - alloc_preg is combinational from entry[spec_head] (zero-latency read).
  - On pop, spec_head advances by 1 at the next clock edge.
  - No bypass: when spec_count == 0, alloc_ready = 0 even if push is high in the same cycle.
- Push:
  - entry[tail] <= commit_p_old.
  - tail advances by 1.
  - arch_head advances by 1, because the retiring instruction's own p_new is now committed.
- Count update:
  - spec_count_n = spec_count + push - pop.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush:
  - spec_head <= arch_head_n, which includes a same-cycle push.
  - spec_count <= FL_DEPTH.
  - alloc_req is ignored in the flush cycle.
  - A push in the flush cycle is still performed.
- Invariant: the number of entries between arch_head and tail is always FL_DEPTH.
- Illegal push:
  - Condition: push && spec_count == FL_DEPTH && !pop.
  - Set overflow_err; it stays set until reset.
  - Do not write the entry and do not advance tail.
- The list never holds tag 0 (x0 is never renamed). Upstream guarantees commit_writes_rd = 0 for rd_arch = 0.

Decomposition:
- Add to cpu_design_params:
  - NUM_PHYS_REGS, NUM_ARCH_REGS, FL_DEPTH.
  - typedef preg_t = logic [PREG_W-1:0], shared with the ROB's p_new/p_old fields.
- Single module; no sub-module.
- Storage is a flop array (FL_DEPTH is small) so that reset initialisation works.
- Pointer and count math sit in an always_comb block, mirroring the "_n" next-state style.

Test Plan:
- Reset, then 32 back-to-back alloc_req → alloc_preg = 32..63 in order, free_count 32 → 0, alloc_ready = 0 on cycle 33.
- From empty: push commit_p_old = 5 → free_count = 1; next cycle alloc_preg = 5 and alloc_ready = 1. Same-cycle alloc_req while empty is not granted.
- Simultaneous pop and push every cycle for 40 cycles → free_count constant, and the pointers wrap past 31 correctly (popped tag order matches push order).
- Pop 10 (tags 32..41), commit 3 with writes_rd (p_old 1, 2, 3), then flush → spec_head = arch_head = 3, free_count = 32, next alloc_preg = 35.
- Flush in the same cycle as a commit push of p_old = 7 → tag 7 is written at tail, arch_head includes that push, free_count = 32.
- Push while free_count = 32 with no pop → overflow_err = 1 and stays 1; tail and contents unchanged. Asserting rst_n mid-run restores the reset values asynchronously.

Source files
------------

// File: rtl/cpu_design_params.sv
// Shared core parameters and types.
// Register-file sizing used by rename, the ROB and the free list.
package cpu_design_params;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;

    localparam int PREG_W  = $clog2(NUM_PHYS_REGS);
    localparam int PTR_W   = $clog2(FL_DEPTH);
    localparam int COUNT_W = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0]  preg_t;
    typedef logic [PTR_W-1:0]   fl_ptr_t;
    typedef logic [COUNT_W-1:0] fl_count_t;

endpackage

// File: rtl/free_list.sv
// Circular list of free physical-register tags between commit and rename.
// A committed head pointer lets a flush restore the list in one cycle.
module free_list
    import cpu_design_params::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_req,
    output logic               alloc_ready,
    output preg_t              alloc_preg,
    input  logic               commit_valid,
    input  logic               commit_writes_rd,
    input  preg_t              commit_p_old,
    input  logic               flush,
    output logic [COUNT_W-1:0] free_count,
    output logic               overflow_err
);

    preg_t     entry_q [FL_DEPTH];
    preg_t     entry_d [FL_DEPTH];
    fl_ptr_t   spec_head_q, spec_head_d;
    fl_ptr_t   arch_head_q, arch_head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_count_t count_q, count_d;
    logic      err_q, err_d;

    logic pop;
    logic push;
    logic illegal;
    logic push_ok;

    assign alloc_ready  = (count_q != '0);
    assign alloc_preg   = entry_q[spec_head_q];
    assign free_count   = count_q;
    assign overflow_err = err_q;

    always_comb begin
        pop     = alloc_req && alloc_ready && !flush;
        push    = commit_valid && commit_writes_rd;
        illegal = push && (count_q == COUNT_W'(FL_DEPTH)) && !pop;
        push_ok = push && !illegal;

        entry_d = entry_q;
        if (push_ok) begin
            entry_d[tail_q] = commit_p_old;
        end

        tail_d      = tail_q + PTR_W'(push_ok);
        arch_head_d = arch_head_q + PTR_W'(push_ok);
        err_d       = err_q | illegal;

        // Recovery rewinds to the committed head, including this cycle's retire.
        if (flush) begin
            spec_head_d = arch_head_d;
            count_d     = COUNT_W'(FL_DEPTH);
        end else begin
            spec_head_d = spec_head_q + PTR_W'(pop);
            count_d     = count_q + COUNT_W'(push_ok) - COUNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry_q[i] <= preg_t'(NUM_ARCH_REGS + i);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= '0;
            count_q     <= COUNT_W'(FL_DEPTH);
            err_q       <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

endmodule
